// File: rtl/fb_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : fb_ctrl_pkg
// Purpose  : Shared types and constants for the framebuffer bank controller.
//            Holds the controller state encoding and the bank reset values.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fb_ctrl_pkg;

  typedef enum logic [1:0] {
    NO_SIGNAL = 2'd0,
    SYNC_WAIT = 2'd1,
    WRITING   = 2'd2,
    READY     = 2'd3
  } fb_state_e;

  localparam logic WR_BANK_RST = 1'b0;
  localparam logic RD_BANK_RST = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fb_bank_controller_sync_edge.sv
//------------------------------------------------------------------------------
// Module   : sync_edge
// Purpose  : Two-flop synchroniser for an asynchronous level, plus a history
//            flop that flags the cycle on which the level becomes active.
// Ports    : clk_48mhz  - system clock
//            reset      - synchronous, active-high
//            i_async    - asynchronous input level
//            o_level    - synchronised level is at the ACTIVE polarity
//            o_assert   - one-cycle pulse on transition into ACTIVE
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_edge #(
  parameter logic ACTIVE = 1'b1
) (
  input  logic clk_48mhz,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_assert
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_level  = (r_sync == ACTIVE);
  assign o_assert = (r_sync == ACTIVE) && (r_hist != ACTIVE);

endmodule

`default_nettype wire

// File: rtl/fb_bank_controller.sv
//------------------------------------------------------------------------------
// Module   : fb_bank_controller
// Purpose  : Double-buffer bank selection between the HDMI framebuffer writer
//            and the LED panel reader. Banks swap only at an LED frame
//            boundary once a full HDMI frame is stored; panels blank when the
//            HDMI source is lost.
// Ports    : clk_48mhz        - system clock
//            reset            - synchronous, active-high
//            i_hdmi_vsync     - asynchronous HDMI vsync
//            i_hdmi_valid     - asynchronous decoder lock
//            i_led_frame_done - one-cycle pulse, LED scan wrapped to row 0
//            o_wr_bank        - bank targeted by the HDMI writer
//            o_wr_enable      - writer may store pixels
//            o_rd_bank        - bank read by the LED scan
//            o_blank          - force LED outputs dark
//            o_swap_count     - completed swaps, saturating
//            o_drop_count     - discarded HDMI frames, saturating
//            o_state_dbg      - current state encoding
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fb_bank_controller
  import fb_ctrl_pkg::*;
#(
  parameter logic VSYNC_ACTIVE  = 1'b0,
  parameter int   VALID_TIMEOUT = 1048576,
  parameter int   VSYNC_TIMEOUT = 4800000,
  parameter int   CNT_WIDTH     = 16
) (
  input  logic                 clk_48mhz,
  input  logic                 reset,
  input  logic                 i_hdmi_vsync,
  input  logic                 i_hdmi_valid,
  input  logic                 i_led_frame_done,
  output logic                 o_wr_bank,
  output logic                 o_wr_enable,
  output logic                 o_rd_bank,
  output logic                 o_blank,
  output logic [CNT_WIDTH-1:0] o_swap_count,
  output logic [CNT_WIDTH-1:0] o_drop_count,
  output logic [1:0]           o_state_dbg
);

  // clog2(N) bits always hold N-1, the highest value a watchdog reaches.
  localparam int VT_W = (VALID_TIMEOUT > 1) ? $clog2(VALID_TIMEOUT) : 1;
  localparam int FT_W = (VSYNC_TIMEOUT > 1) ? $clog2(VSYNC_TIMEOUT) : 1;
  localparam logic [VT_W-1:0] c_VT_LAST = VT_W'(VALID_TIMEOUT - 1);
  localparam logic [FT_W-1:0] c_FT_LAST = FT_W'(VSYNC_TIMEOUT - 1);

  logic w_fse;
  logic w_valid;
  logic w_vsync_level;
  logic w_valid_edge;

  sync_edge #(.ACTIVE(VSYNC_ACTIVE)) u_sync_vsync (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .i_async   (i_hdmi_vsync),
    .o_level   (w_vsync_level),
    .o_assert  (w_fse)
  );

  sync_edge #(.ACTIVE(1'b1)) u_sync_valid (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .i_async   (i_hdmi_valid),
    .o_level   (w_valid),
    .o_assert  (w_valid_edge)
  );

  fb_state_e            r_state, w_state_nxt;
  logic                 r_wr_bank, w_wr_bank_nxt;
  logic                 r_rd_bank, w_rd_bank_nxt;
  logic                 r_wr_enable, w_wr_enable_nxt;
  logic                 r_blank, w_blank_nxt;
  logic [CNT_WIDTH-1:0] r_swap_count, w_swap_count_nxt;
  logic [CNT_WIDTH-1:0] r_drop_count, w_drop_count_nxt;
  logic [VT_W-1:0]      r_vt, w_vt_nxt;
  logic [FT_W-1:0]      r_ft, w_ft_nxt;
  logic                 w_timeout;

  assign w_timeout = (r_state != NO_SIGNAL) &&
                     ((r_vt == c_VT_LAST) || (r_ft == c_FT_LAST));

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_state      <= NO_SIGNAL;
      r_wr_bank    <= WR_BANK_RST;
      r_rd_bank    <= RD_BANK_RST;
      r_wr_enable  <= 1'b0;
      r_blank      <= 1'b1;
      r_swap_count <= '0;
      r_drop_count <= '0;
      r_vt         <= '0;
      r_ft         <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_bank    <= w_wr_bank_nxt;
      r_rd_bank    <= w_rd_bank_nxt;
      r_wr_enable  <= w_wr_enable_nxt;
      r_blank      <= w_blank_nxt;
      r_swap_count <= w_swap_count_nxt;
      r_drop_count <= w_drop_count_nxt;
      r_vt         <= w_vt_nxt;
      r_ft         <= w_ft_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_wr_bank_nxt    = r_wr_bank;
    w_rd_bank_nxt    = r_rd_bank;
    w_blank_nxt      = r_blank;
    w_swap_count_nxt = r_swap_count;
    w_drop_count_nxt = r_drop_count;
    w_vt_nxt         = r_vt;
    w_ft_nxt         = r_ft;

    if (w_timeout) begin
      // Watchdog wins over any coincident frame events; banks stay put.
      w_state_nxt = NO_SIGNAL;
      w_blank_nxt = 1'b1;
      w_vt_nxt    = '0;
      w_ft_nxt    = '0;
    end else if (r_state == NO_SIGNAL) begin
      w_vt_nxt = '0;
      w_ft_nxt = '0;
      if (w_valid) begin
        w_state_nxt = SYNC_WAIT;
      end
    end else begin
      w_vt_nxt = w_valid ? '0 : r_vt + VT_W'(1);
      w_ft_nxt = w_fse   ? '0 : r_ft + FT_W'(1);
      case (r_state)
        SYNC_WAIT: if (w_fse) w_state_nxt = WRITING;
        WRITING:   if (w_fse) w_state_nxt = READY;
        READY: begin
          if (i_led_frame_done) begin
            w_wr_bank_nxt    = r_rd_bank;
            w_rd_bank_nxt    = r_wr_bank;
            w_blank_nxt      = 1'b0;
            w_state_nxt      = WRITING;
            w_swap_count_nxt = (&r_swap_count) ? r_swap_count
                                               : r_swap_count + CNT_WIDTH'(1);
          end
          // A frame ending while one is still pending was written nowhere.
          if (w_fse) begin
            w_drop_count_nxt = (&r_drop_count) ? r_drop_count
                                               : r_drop_count + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end

    w_wr_enable_nxt = (w_state_nxt == WRITING);
  end

  assign o_wr_bank    = r_wr_bank;
  assign o_rd_bank    = r_rd_bank;
  assign o_wr_enable  = r_wr_enable;
  assign o_blank      = r_blank;
  assign o_swap_count = r_swap_count;
  assign o_drop_count = r_drop_count;
  assign o_state_dbg  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_fb_bank_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_fb_bank_controller
// Purpose  : Self-checking bench for fb_bank_controller: a frame-level
//            reference model compared every cycle, plus directed scenarios
//            with hand-computed expectations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fb_bank_controller;

  localparam logic ACT   = 1'b0;
  localparam int   VT    = 500;
  localparam int   FT    = 1000;
  localparam int   CW    = 4;
  localparam int   CMAX  = (1 << CW) - 1;

  logic          clk_48mhz = 1'b0;
  logic          reset = 1'b1;
  logic          vsync = 1'b1;
  logic          valid = 1'b1;
  logic          led = 1'b0;
  logic          wr_bank, wr_en, rd_bank, blank;
  logic [CW-1:0] swap_cnt, drop_cnt;
  logic [1:0]    state;

  int n_checks = 0;
  int n_pass   = 0;

  fb_bank_controller #(
    .VSYNC_ACTIVE  (ACT),
    .VALID_TIMEOUT (VT),
    .VSYNC_TIMEOUT (FT),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk_48mhz        (clk_48mhz),
    .reset            (reset),
    .i_hdmi_vsync     (vsync),
    .i_hdmi_valid     (valid),
    .i_led_frame_done (led),
    .o_wr_bank        (wr_bank),
    .o_wr_enable      (wr_en),
    .o_rd_bank        (rd_bank),
    .o_blank          (blank),
    .o_swap_count     (swap_cnt),
    .o_drop_count     (drop_cnt),
    .o_state_dbg      (state)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference model: frame-level behaviour. An asynchronous input sample
  // influences the controller two edges after it is taken.
  int m_st, m_wb, m_rb, m_bl, m_sc, m_dc, m_vt, m_ft;
  logic s1_vs, s2_vs, s3_vs, s1_va, s2_va;

  always @(posedge clk_48mhz) begin
    if (reset) begin
      m_st = 0; m_wb = 0; m_rb = 1; m_bl = 1; m_sc = 0; m_dc = 0;
      m_vt = 0; m_ft = 0;
      s1_vs = 0; s2_vs = 0; s3_vs = 0; s1_va = 0; s2_va = 0;
    end else begin
      automatic bit f = (s2_vs == ACT) && (s3_vs != ACT);
      automatic bit v = s2_va;
      if (m_st != 0 && (m_vt == VT - 1 || m_ft == FT - 1)) begin
        m_st = 0; m_bl = 1; m_vt = 0; m_ft = 0;
      end else if (m_st == 0) begin
        m_vt = 0; m_ft = 0;
        if (v) m_st = 1;
      end else begin
        m_vt = v ? 0 : m_vt + 1;
        m_ft = f ? 0 : m_ft + 1;
        if (m_st == 1) begin
          if (f) m_st = 2;
        end else if (m_st == 2) begin
          if (f) m_st = 3;
        end else begin
          if (led) begin
            automatic int t = m_wb;
            m_wb = m_rb; m_rb = t;
            m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
            m_bl = 0; m_st = 2;
          end
          if (f) m_dc = (m_dc < CMAX) ? m_dc + 1 : CMAX;
        end
      end
      s3_vs = s2_vs; s2_vs = s1_vs; s1_vs = vsync;
      s2_va = s1_va; s1_va = valid;
    end
  end

  always @(negedge clk_48mhz) begin
    chk("state",     int'(state),    m_st);
    chk("wr_bank",   int'(wr_bank),  m_wb);
    chk("rd_bank",   int'(rd_bank),  m_rb);
    chk("wr_enable", int'(wr_en),    (m_st == 2) ? 1 : 0);
    chk("blank",     int'(blank),    m_bl);
    chk("swap_cnt",  int'(swap_cnt), m_sc);
    chk("drop_cnt",  int'(drop_cnt), m_dc);
    chk("bank_diff", int'(wr_bank != rd_bank), 1);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_48mhz);
  endtask

  task automatic do_reset();
    reset = 1'b1; vsync = 1'b1; valid = 1'b1; led = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b0; tick(2);
    vsync = 1'b1; tick(3);
  endtask

  task automatic pulse_led();
    led = 1'b1; tick(1);
    led = 1'b0; tick(1);
  endtask

  task automatic go_ready();
    do_reset(); tick(4);
    pulse_vsync(); pulse_vsync();
  endtask

  task automatic wait_state(input string name, input int want, input int limit);
    int k = 0;
    while (int'(state) != want && k < limit) begin
      tick(1); k++;
    end
    chk(name, int'(state), want);
  endtask

  initial begin
    // Reset, valid held, no vsync: watchdog returns to NO_SIGNAL.
    tick(3);
    chk("rst_state", int'(state), 0);
    chk("rst_blank", int'(blank), 1);
    chk("rst_rd",    int'(rd_bank), 1);
    reset = 1'b0;
    tick(4);
    chk("t1_syncwait", int'(state), 1);
    wait_state("t1_vs_timeout", 0, FT + 50);
    chk("t1_blank", int'(blank), 1);
    chk("t1_wr",    int'(wr_bank), 0);
    chk("t1_rd",    int'(rd_bank), 1);

    // Nominal flow.
    do_reset(); tick(4);
    chk("t2_sw", int'(state), 1);
    pulse_vsync();
    chk("t2_writing", int'(state), 2);
    chk("t2_wen1",    int'(wr_en), 1);
    pulse_vsync();
    chk("t2_ready",   int'(state), 3);
    chk("t2_wen0",    int'(wr_en), 0);
    led = 1'b1; tick(1); led = 1'b0;
    chk("t2_swap_st", int'(state), 2);
    chk("t2_wr",      int'(wr_bank), 1);
    chk("t2_rd",      int'(rd_bank), 0);
    chk("t2_blank",   int'(blank), 0);
    chk("t2_swaps",   int'(swap_cnt), 1);
    chk("t2_wen",     int'(wr_en), 1);
    tick(1);

    // Slow LED: three dropped frames while READY.
    go_ready();
    pulse_vsync(); pulse_vsync(); pulse_vsync();
    chk("t3_drops", int'(drop_cnt), 3);
    chk("t3_state", int'(state), 3);
    chk("t3_wr",    int'(wr_bank), 0);
    pulse_led();
    chk("t3_swaps", int'(swap_cnt), 1);

    // Coincident frame end and LED wrap in READY, then in WRITING.
    go_ready();
    vsync = 1'b0; tick(2); led = 1'b1; tick(1); led = 1'b0; vsync = 1'b1;
    chk("t4_state", int'(state), 2);
    chk("t4_swaps", int'(swap_cnt), 1);
    chk("t4_drops", int'(drop_cnt), 1);
    chk("t4_wr",    int'(wr_bank), 1);
    tick(3);
    vsync = 1'b0; tick(2); led = 1'b1; tick(1); led = 1'b0; vsync = 1'b1;
    chk("t4b_state", int'(state), 3);
    chk("t4b_swaps", int'(swap_cnt), 1);
    chk("t4b_wr",    int'(wr_bank), 1);
    tick(3);

    // Source loss while WRITING.
    go_ready();
    pulse_led();
    valid = 1'b0;
    wait_state("t5_lost", 0, VT + 50);
    tick(1);
    chk("t5_blank", int'(blank), 1);
    chk("t5_wen",   int'(wr_en), 0);
    chk("t5_wr",    int'(wr_bank), 1);
    chk("t5_rd",    int'(rd_bank), 0);
    valid = 1'b1;
    tick(4);
    chk("t5_resync", int'(state), 1);

    // Saturation of swap counter, then reset from READY.
    go_ready();
    for (int i = 0; i < 20; i++) begin
      pulse_led();
      pulse_vsync();
    end
    chk("t6_sat", int'(swap_cnt), CMAX);
    chk("t6_ready", int'(state), 3);
    reset = 1'b1; tick(1);
    chk("t6_rst_state", int'(state), 0);
    chk("t6_rst_wr",    int'(wr_bank), 0);
    chk("t6_rst_rd",    int'(rd_bank), 1);
    chk("t6_rst_wen",   int'(wr_en), 0);
    chk("t6_rst_blank", int'(blank), 1);
    chk("t6_rst_swaps", int'(swap_cnt), 0);
    chk("t6_rst_drops", int'(drop_cnt), 0);
    reset = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
